// File: rtl/dbg_trace_monitor.sv
// Debug trace monitor: circular commit trace with PC trigger / post-capture / freeze and
// saturating event counters. Define DBG_TRACE_TIMESTAMP_EN to prepend a 32-bit cycle stamp.
module dbg_trace_monitor #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_RS    = 5,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ROB_IDX_W = 3,
  parameter int unsigned WRAP_MODE = 1,
  parameter int unsigned POST_TRIG = 4,
`ifdef DBG_TRACE_TIMESTAMP_EN
  localparam int unsigned TS_W     = 32,
`else
  localparam int unsigned TS_W     = 0,
`endif
  localparam int unsigned ENTRY_W  = TS_W + 69 + ROB_IDX_W,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    commit_valid,
  input  logic [31:0]             commit_pc,
  input  logic [4:0]              commit_rd,
  input  logic [31:0]             commit_data,
  input  logic [ROB_IDX_W-1:0]    commit_rob,
  input  logic                    flush,
  input  logic [NUM_RS-1:0]       rs_exec,
  input  logic                    trig_en,
  input  logic [31:0]             trig_pc,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [ENTRY_W-1:0]      rd_entry,
  output logic [AW:0]             count,
  output logic                    overflow,
  output logic [1:0]              state,
  output logic [NUM_RS*CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0]        commit_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_POST   = 2'd1,
    S_FROZEN = 2'd2
  } state_e;

  localparam int unsigned PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  state_e              st_q;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         cnt_q;
  logic                ovf_q;
  logic [PW-1:0]       post_q;
  logic [CNT_W-1:0]    exec_q [NUM_RS];
  logic [CNT_W-1:0]    commit_q;
  logic [CNT_W-1:0]    flush_q;
  logic                capture;
  logic                pop;
  logic                full;
  logic                write_en;
  logic                hit;
  logic [ENTRY_W-1:0]  new_entry;

`ifdef DBG_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ts_q <= '0;
    else if (clear) ts_q <= '0;
    else            ts_q <= ts_q + 32'd1;
  end

  assign new_entry = {ts_q, commit_pc, commit_rd, commit_data, commit_rob};
`else
  assign new_entry = {commit_pc, commit_rd, commit_data, commit_rob};
`endif

  assign full     = (cnt_q == FULL_CNT);
  assign capture  = commit_valid && (st_q != S_FROZEN) && !clear;
  assign pop      = (cnt_q != '0) && rd_ready && !clear;
  // When full, a same-cycle pop frees the slot; otherwise only wrap mode may overwrite.
  assign write_en = capture && (!full || pop || (WRAP_MODE != 0));
  assign hit      = trig_en && (commit_pc == trig_pc);

  always_ff @(posedge clk) begin
    if (write_en) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      post_q <= '0;
      st_q   <= S_RUN;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      post_q <= '0;
      st_q   <= S_RUN;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop || (write_en && full)) rd_ptr <= rd_ptr + 1'b1;
      if (write_en && !full && !pop)  cnt_q <= cnt_q + 1'b1;
      else if (pop && !write_en)      cnt_q <= cnt_q - 1'b1;
      if (capture && full && !pop) ovf_q <= 1'b1;
      if (capture) begin
        case (st_q)
          S_RUN: begin
            if (hit) begin
              if (POST_TRIG == 0) begin
                st_q <= S_FROZEN;
              end else begin
                st_q   <= S_POST;
                post_q <= PW'(POST_TRIG);
              end
            end
          end
          S_POST: begin
            post_q <= post_q - 1'b1;
            if (post_q == PW'(1)) st_q <= S_FROZEN;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    return (ev && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_RS; i++) exec_q[i] <= '0;
      commit_q <= '0;
      flush_q  <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_RS; i++) exec_q[i] <= '0;
      commit_q <= '0;
      flush_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RS; i++) exec_q[i] <= sat_inc(exec_q[i], rs_exec[i]);
      commit_q <= sat_inc(commit_q, commit_valid);
      flush_q  <= sat_inc(flush_q, flush);
    end
  end

  for (genvar g = 0; g < NUM_RS; g++) begin : g_exec
    assign exec_cnt[g*CNT_W +: CNT_W] = exec_q[g];
  end

  assign rd_valid   = (cnt_q != '0);
  assign rd_entry   = rd_valid ? mem[rd_ptr] : '0;
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign state      = st_q;
  assign commit_cnt = commit_q;
  assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_dbg_trace_monitor.sv
// Directed bench for dbg_trace_monitor: wrap, drop and short-counter/no-post variants
// share one stimulus stream; a queue scoreboard checks every popped entry.
module tb_dbg_trace_monitor;
`ifdef DBG_TRACE_TIMESTAMP_EN
  localparam int EW = 104;
`else
  localparam int EW = 72;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [2:0]  commit_rob;
  logic        flush;
  logic [4:0]  rs_exec;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        rd_ready;

  logic          a_rd_valid, b_rd_valid, c_rd_valid;
  logic [EW-1:0] a_rd_entry, b_rd_entry, c_rd_entry;
  logic [4:0]    a_count, b_count;
  logic [2:0]    c_count;
  logic          a_overflow, b_overflow, c_overflow;
  logic [1:0]    a_state, b_state, c_state;
  logic [79:0]   a_exec, b_exec;
  logic [19:0]   c_exec;
  logic [15:0]   a_commit, b_commit, a_flush, b_flush;
  logic [3:0]    c_commit, c_flush;

  dbg_trace_monitor u_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_rob(commit_rob), .flush(flush), .rs_exec(rs_exec), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(a_rd_valid), .rd_entry(a_rd_entry),
    .count(a_count), .overflow(a_overflow), .state(a_state), .exec_cnt(a_exec),
    .commit_cnt(a_commit), .flush_cnt(a_flush)
  );

  dbg_trace_monitor #(.WRAP_MODE(0)) u_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_rob(commit_rob), .flush(flush), .rs_exec(rs_exec), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(b_rd_valid), .rd_entry(b_rd_entry),
    .count(b_count), .overflow(b_overflow), .state(b_state), .exec_cnt(b_exec),
    .commit_cnt(b_commit), .flush_cnt(b_flush)
  );

  dbg_trace_monitor #(.DEPTH(4), .CNT_W(4), .POST_TRIG(0)) u_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_rob(commit_rob), .flush(flush), .rs_exec(rs_exec), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(c_rd_valid), .rd_entry(c_rd_entry),
    .count(c_count), .overflow(c_overflow), .state(c_state), .exec_cnt(c_exec),
    .commit_cnt(c_commit), .flush_cnt(c_flush)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [71:0] qa[$];
  logic [71:0] qb[$];
  int ms = 0;
  int mpost = 0;
  int msc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [31:0] pc);
    return {pc, pc[6:2], pc ^ 32'hA5A5_0000, pc[4:2]};
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ms = 0;
    mpost = 0;
    msc = 0;
  endtask

  // One clock of stimulus; pops are scored against the queue head before the edge.
  task automatic step(input bit cv, input logic [31:0] pc, input bit fl,
                      input logic [4:0] rs, input bit rdy, input bit clr);
    bit pa, pb;
    pa = rdy && (qa.size() != 0);
    pb = rdy && (qb.size() != 0);
    if (pa) chk("a_pop_entry", a_rd_entry[71:0], qa[0]);
    if (pb) chk("b_pop_entry", b_rd_entry[71:0], qb[0]);
    commit_valid = cv;
    commit_pc    = pc;
    commit_rd    = pc[6:2];
    commit_data  = pc ^ 32'hA5A5_0000;
    commit_rob   = pc[4:2];
    flush        = fl;
    rs_exec      = rs;
    rd_ready     = rdy;
    clear        = clr;
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    flush        = 1'b0;
    rs_exec      = '0;
    rd_ready     = 1'b0;
    clear        = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (pa) qa.delete(0);
      if (pb) qb.delete(0);
      if (cv && ms != 2) begin
        if (qa.size() == 16) qa.delete(0);
        qa.push_back(mk(pc));
        if (qb.size() < 16) qb.push_back(mk(pc));
        if (ms == 0 && trig_en && pc == trig_pc) begin
          ms = 1;
          mpost = 4;
        end else if (ms == 1) begin
          mpost--;
          if (mpost == 0) ms = 2;
        end
      end
      if (cv && msc != 2 && trig_en && pc == trig_pc) msc = 2;
    end
  endtask

  initial begin
    logic [31:0] pc;
    reset_n = 1'b0; clear = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_rd = '0;
    commit_data = '0; commit_rob = '0; flush = 1'b0; rs_exec = '0; trig_en = 1'b0;
    trig_pc = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", a_count, 0);
    chk("rst_rd_valid", a_rd_valid, 0);
    chk("rst_rd_entry", a_rd_entry, 0);
    chk("rst_state", a_state, 0);
    chk("rst_overflow", a_overflow, 0);
    chk("rst_commit_cnt", a_commit, 0);
    reset_n = 1'b1;

    // Basic in-order capture and readout
    step(1, 32'h60, 0, 0, 0, 0);
    chk("first_latency_valid", a_rd_valid, 1);
    step(1, 32'h64, 0, 0, 0, 0);
    step(1, 32'h68, 0, 0, 0, 0);
    chk("basic_count", a_count, 3);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    chk("basic_drained_a", a_rd_valid, 0);
    chk("basic_drained_b", b_rd_valid, 0);

    // Full buffer: simultaneous push/pop, then overwrite vs drop
    step(0, 0, 0, 0, 0, 1);
    chk("clear_c_count", c_count, 0);
    chk("clear_c_overflow", c_overflow, 0);
    chk("clear_c_rd_valid", c_rd_valid, 0);
    chk("clear_c_rd_entry", c_rd_entry, 0);
    for (int k = 0; k < 16; k++) step(1, 32'h100 + 32'(4 * k), 0, 0, 0, 0);
    chk("full_count", a_count, 16);
    chk("full_overflow", a_overflow, 0);
    step(1, 32'h140, 0, 0, 1, 0);
    chk("pushpop_a_count", a_count, 16);
    chk("pushpop_a_overflow", a_overflow, 0);
    chk("pushpop_b_count", b_count, 16);
    chk("pushpop_b_overflow", b_overflow, 0);
    for (int k = 0; k < 4; k++) step(1, 32'h144 + 32'(4 * k), 0, 0, 0, 0);
    chk("wrap_a_count", a_count, 16);
    chk("wrap_a_overflow", a_overflow, 1);
    chk("drop_b_count", b_count, 16);
    chk("drop_b_overflow", b_overflow, 1);
    chk("wrap_a_oldest_pc", a_rd_entry[71:40], 32'h114);
    chk("drop_b_oldest_pc", b_rd_entry[71:40], 32'h104);
    repeat (16) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("empty_pop_count", a_count, 0);
    chk("empty_pop_entry", a_rd_entry, 0);

    // Trigger, post-trigger capture, freeze
    step(0, 0, 0, 0, 0, 1);
    trig_en = 1'b1;
    trig_pc = 32'h80;
    for (int k = 0; k < 10; k++) begin
      pc = 32'h78 + 32'(4 * k);
      step(1, pc, 0, 0, 0, 0);
      if (pc == 32'h80) begin
        chk("trig_a_post", a_state, 1);
        chk("trig_c_frozen", c_state, 2);
      end
      if (pc == 32'h8C) chk("trig_a_still_post", a_state, 1);
      if (pc == 32'h90) chk("trig_a_frozen", a_state, 2);
    end
    chk("trig_count", a_count, 7);
    chk("trig_state_model", a_state, ms);
    chk("trig_b_state", b_state, ms);
    chk("frozen_commit_cnt", a_commit, 10);
    repeat (7) step(0, 0, 0, 0, 1, 0);
    chk("frozen_after_drain", a_state, 2);
    trig_en = 1'b0;

    // Exec counters, saturation, clear priority
    step(0, 0, 0, 0, 0, 1);
    chk("clear_c_state", c_state, 0);
    repeat (10) step(0, 0, 0, 5'b10101, 0, 0);
    chk("exec10_a", a_exec, {16'd10, 16'd0, 16'd10, 16'd0, 16'd10});
    repeat (10) step(0, 0, 0, 5'b10101, 0, 0);
    chk("exec20_a", a_exec, {16'd20, 16'd0, 16'd20, 16'd0, 16'd20});
    chk("exec20_b", b_exec, {16'd20, 16'd0, 16'd20, 16'd0, 16'd20});
    chk("exec_sat_c", c_exec, {4'd15, 4'd0, 4'd15, 4'd0, 4'd15});
    step(1, 32'h2A0, 1, 5'b11111, 0, 1);
    chk("clr_exec_a", a_exec, 0);
    chk("clr_exec_c", c_exec, 0);
    chk("clr_commit_a", a_commit, 0);
    chk("clr_flush_a", a_flush, 0);
    chk("clr_count_a", a_count, 0);
    chk("clr_commit_c", c_commit, 0);
    chk("clr_flush_c", c_flush, 0);

    // Commit and flush together
    step(1, 32'h200, 1, 0, 0, 0);
    chk("cf_count", a_count, 1);
    chk("cf_commit_cnt", a_commit, 1);
    chk("cf_flush_cnt", a_flush, 1);
    chk("cf_b_commit", b_commit, 1);
    chk("cf_b_flush", b_flush, 1);
    step(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-stream, between clock edges
    trig_en = 1'b1;
    trig_pc = 32'h300;
    for (int k = 0; k < 5; k++) step(1, 32'h2F8 + 32'(4 * k), 0, 0, 0, 0);
    chk("pre_rst_count", a_count, 5);
    chk("pre_rst_state", a_state, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", a_count, 0);
    chk("async_rst_state", a_state, 0);
    chk("async_rst_rd_valid", a_rd_valid, 0);
    chk("async_rst_commit", a_commit, 0);
    chk("async_rst_c_state", c_state, 0);
    model_reset();
    #2;
    reset_n = 1'b1;
    trig_en = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
